// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-channel valid/ready stream multiplexer with arbiter and registered output
module stream_mux_arb #(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 8,
    parameter int ARB_MODE = 1,
    parameter int CH_W     = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    logic [CH_W-1:0]  ptr;
    logic [CH_W-1:0]  start;
    logic [CH_W:0]    idx;
    logic [CH_W-1:0]  gnt_idx;
    logic             gnt_found;
    logic [N_CH-1:0]  grant;
    logic [WIDTH-1:0] sel_data;
    logic             load;
    logic             xfer;

    // Fixed priority always searches from channel 0; round-robin starts at ptr.
    assign start = (ARB_MODE == 1) ? ptr : '0;

    // Pick the first valid channel in circular order from start.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = {1'b0, start} + (CH_W+1)'(k);
            if (idx >= (CH_W+1)'(N_CH)) begin
                idx = idx - (CH_W+1)'(N_CH);
            end
            if (!gnt_found && in_valid[idx[CH_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[CH_W-1:0];
            end
        end
    end

    // One-hot grant vector and the word of the granted channel.
    always_comb begin
        grant = '0;
        if (gnt_found) begin
            grant[gnt_idx] = 1'b1;
        end
        sel_data = in_data[gnt_idx*WIDTH +: WIDTH];
    end

    // The output register can take a word when empty or draining this cycle.
    assign load     = ~out_valid | out_ready;
    assign in_ready = grant & {N_CH{load & rst_n}};
    assign xfer     = |(in_valid & in_ready);

    // Output register: capture on transfer, empty on drain, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the channel that was served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer && (ARB_MODE == 1)) begin
            ptr <= (gnt_idx == CH_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready));

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_ch)));

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb/tb_stream_mux_arb.sv - randomized and directed bench for stream_mux_arb in both arbitration modes
module tb_stream_mux_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic           out_ready = 1'b0;

    logic [N-1:0]   rdy_rr, rdy_fp;
    logic           ov_rr, ov_fp;
    logic [W-1:0]   od_rr, od_fp;
    logic [1:0]     oc_rr, oc_fp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_mux_arb #(.N_CH(N), .WIDTH(W), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_ch(oc_rr),
        .out_ready(out_ready)
    );

    stream_mux_arb #(.N_CH(N), .WIDTH(W), .ARB_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_fp), .out_valid(ov_fp), .out_data(od_fp), .out_ch(oc_fp),
        .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, index 0 = fixed priority, index 1 = round-robin.
    logic         mv [2];
    logic [W-1:0] md [2];
    int           mc [2];
    int           mp [2];

    function automatic int winner(input int mode, input int ptr, input logic [N-1:0] v);
        int s;
        s = (mode == 1) ? ptr : 0;
        for (int k = 0; k < N; k++) begin
            if (v[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int m);
        logic [N-1:0] r;
        int w;
        r = '0;
        w = winner(m, mp[m], in_valid);
        if (rst_n && (!mv[m] || out_ready) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                mv[m] <= 1'b0;
                md[m] <= '0;
                mc[m] <= 0;
                mp[m] <= 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if ((!mv[m] || out_ready) && winner(m, mp[m], in_valid) >= 0) begin
                    mv[m] <= 1'b1;
                    md[m] <= in_data[winner(m, mp[m], in_valid)*W +: W];
                    mc[m] <= winner(m, mp[m], in_valid);
                    if (m == 1) mp[m] <= (winner(m, mp[m], in_valid) + 1) % N;
                end else if (mv[m] && out_ready) begin
                    mv[m] <= 1'b0;
                end
            end
        end
    end

    // Compare both DUTs against the model every cycle, away from the clock edge.
    always @(negedge clk) begin
        chk("rr_in_ready",  32'(rdy_rr), 32'(exp_ready(1)));
        chk("rr_out_valid", 32'(ov_rr),  32'(mv[1]));
        chk("rr_out_data",  32'(od_rr),  32'(md[1]));
        chk("rr_out_ch",    32'(oc_rr),  32'(mc[1]));
        chk("fp_in_ready",  32'(rdy_fp), 32'(exp_ready(0)));
        chk("fp_out_valid", 32'(ov_fp),  32'(mv[0]));
        chk("fp_out_data",  32'(od_fp),  32'(md[0]));
        chk("fp_out_ch",    32'(oc_fp),  32'(mc[0]));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        tick; tick;
        @(negedge clk);
        chk("reset_out_valid", 32'(ov_rr), 32'd0);
        chk("reset_out_data",  32'(od_rr), 32'd0);
        chk("reset_out_ch",    32'(oc_rr), 32'd0);
        chk("reset_in_ready",  32'(rdy_rr), 32'd0);

        // Single channel, then wrap from ptr=3 and drain
        tick;
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 4'b0100; in_data = 32'h00A5_0000;
        @(negedge clk);
        chk("single_in_ready", 32'(rdy_rr), 32'h4);
        tick;
        in_valid = 4'b0001; in_data = 32'h0000_005A;
        @(negedge clk);
        chk("single_out_valid", 32'(ov_rr), 32'd1);
        chk("single_out_data",  32'(od_rr), 32'hA5);
        chk("single_out_ch",    32'(oc_rr), 32'd2);
        chk("wrap_in_ready",    32'(rdy_rr), 32'h1);
        tick;
        in_valid = 4'b0000;
        @(negedge clk);
        chk("wrap_out_ch", 32'(oc_rr), 32'd0);
        tick;
        in_valid = 4'b1111; in_data = 32'h1312_1110;
        @(negedge clk);
        chk("drain_out_valid", 32'(ov_rr), 32'd0);
        chk("drain_out_data",  32'(od_rr), 32'h5A);
        chk("ptr_after_wrap",  32'(rdy_rr), 32'h2);

        // Round-robin fairness and fixed priority from reset
        tick; rst_n = 1'b0;
        tick; rst_n = 1'b1;
        in_valid = 4'b1111; in_data = 32'h1312_1110; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("fp_ready_fixed", 32'(rdy_fp), 32'h1);
            if (i > 0) begin
                chk("rr_fair_valid", 32'(ov_rr), 32'd1);
                chk("rr_fair_ch",    32'(oc_rr), 32'((i - 1) % 4));
                chk("rr_fair_data",  32'(od_rr), 32'(8'h10 + (i - 1) % 4));
                chk("fp_fixed_ch",   32'(oc_fp), 32'd0);
            end
            tick;
        end

        // Backpressure holding ch1 = 0x3C
        rst_n = 1'b0;
        tick; rst_n = 1'b1;
        in_valid = 4'b0010; in_data = 32'h0000_3C00; out_ready = 1'b1;
        tick;
        out_ready = 1'b0; in_valid = 4'b1111; in_data = 32'h4433_3C11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  32'(rdy_rr), 32'h0);
            chk("bp_out_valid", 32'(ov_rr), 32'd1);
            chk("bp_out_data",  32'(od_rr), 32'h3C);
            chk("bp_out_ch",    32'(oc_rr), 32'd1);
            tick;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(rdy_rr), 32'h4);
        tick;
        @(negedge clk);
        chk("bp_release_ch",   32'(oc_rr), 32'd2);
        chk("bp_release_data", 32'(od_rr), 32'h33);

        // Asynchronous reset between edges while a word is held
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", 32'(ov_rr), 32'd0);
        chk("areset_out_data",  32'(od_rr), 32'd0);
        chk("areset_out_ch",    32'(oc_rr), 32'd0);
        tick;
        rst_n = 1'b1; in_valid = 4'b1010;
        @(negedge clk);
        chk("areset_first_grant", 32'(rdy_rr), 32'h2);
        tick;
        @(negedge clk);
        chk("areset_first_ch", 32'(oc_rr), 32'd1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            tick;
            rst_n     = ($urandom_range(0, 299) != 0);
            in_valid  = N'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        tick;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
